swt_obs_misr: RTL and testbench
===============================

# swt_obs_misr

Parametrised observation block for memory Scan Write-Thru address/control paths. It folds the observed pins into `OBS_FLOP_NUM` groups with XOR. Each group result is captured either directly or into a multiple-input signature register (MISR). An on-demand serial unload with a start/done handshake lets the signature be read out without a scan shift of the whole design. It sits beside each SWT memory wrapper and is clocked by the memory port clock.

## Interface
- `OBS_PIN_NUM`, 1: total width of the concatenated address/control signals.
- `OBS_XOR_SIZE`, 3: number of inputs folded per XOR group.
- `OBS_FLOP_NUM`, ceil(OBS_PIN_NUM/OBS_XOR_SIZE): number of observation/signature flops (N).
- `TAP_MASK`, 0 (N bits): MISR feedback taps. Bit k set means `Sig[N-1]` is XORed into bit k.
- `Clock` in 1: memory port clock. Single clock domain.
- `Reset` in 1: reset is synchronous and active-high.
- `In` in OBS_PIN_NUM: observed signals, e.g. {ADDR_toMem, WE, RE, CS}.
- `CaptureEn` in 1: update the signature this cycle.
- `MisrMode` in 1: 0 = direct capture, 1 = MISR accumulate.
- `UnloadStart` in 1: request a serial unload. Sampled only in IDLE.
- `ScanOut` out 1: serial signature bit, LSB first.
- `ScanOutValid` out 1: `ScanOut` is valid this cycle.
- `UnloadDone` out 1: one-cycle pulse when the unload completes.
- `Busy` out 1: high when the FSM is not IDLE.
- `Out` out N: registered signature `Sig`.

## Operation
- XOR fold:
  - `Obs[i] = ^In[i*S+S-1 : i*S]` for every group except the last, where S = OBS_XOR_SIZE.
  - The last group is `^In[OBS_PIN_NUM-1 : (N-1)*S]` and may hold fewer than S bits.
- Direct capture: `Sig <= Obs`.
- MISR update:
  - `next[0] = Sig[N-1] ^ Obs[0]`.
  - `next[k] = Sig[k-1] ^ Obs[k] ^ (TAP_MASK[k] & Sig[N-1])` for k = 1..N-1.
  - When N = 1: `next[0] = Sig[0] ^ Obs[0]`.
- FSM states: IDLE, UNLOAD, DONE.
  - IDLE → UNLOAD when `UnloadStart` is high. The bit counter loads N-1.
  - UNLOAD: each cycle, rotate `Sig` right by one (`Sig[0]` goes to `Sig[N-1]`) and decrement the counter. At count 0, go to DONE.
  - DONE → IDLE unconditionally.
- Captures (`CaptureEn`) take effect only in IDLE. They are ignored in UNLOAD and DONE.
- `UnloadStart` and `CaptureEn` high together in IDLE: the unload wins and the capture is dropped.
- `UnloadStart` outside IDLE is ignored. It is not queued.
- After a full unload, `Sig` has rotated N times and equals its pre-unload value.
- Counter width is $clog2(N+1).

## Timing
- Reset values: `Sig`/`Out` = 0, `ScanOut` = 0, `ScanOutValid` = 0, `UnloadDone` = 0, `Busy` = 0, state = IDLE.
- Capture latency: `In` sampled at edge t appears on `Out` after edge t.
- Unload accepted at edge t:
  - `ScanOutValid` and `Busy` are high for N cycles.
  - `ScanOut = Sig[0]`, giving Sig bits 0..N-1 in order.
  - `UnloadDone` and `Busy` are high for the following cycle.
  - IDLE is reached on the next edge.
- Reset asserted mid-unload: on the next edge, state = IDLE, `Sig` = 0, and all outputs return to their reset values. No `UnloadDone` is issued.
- `ScanOut` is 0 whenever `ScanOutValid` is low.

## Configuration
- `SWT_OBS_MISR_EN` defined: MISR logic and the `TAP_MASK` feedback are compiled in, and `MisrMode` selects the update.
- `SWT_OBS_MISR_EN` undefined: `MisrMode` is ignored and every capture is direct. Unload behaviour is unchanged.

## Structure
- Package `swt_obs_pkg` contains:
  - The FSM state enum (IDLE, UNLOAD, DONE).
  - The function `obs_flop_num(pins, xor_size)` for the ceil division.
- Sub-module `swt_obs_xor_compact`: purely combinational XOR fold parametrised by OBS_PIN_NUM, OBS_XOR_SIZE and OBS_FLOP_NUM.
- The top module owns the signature register, the FSM and the counter.

## Test plan
- Direct capture, PIN=7, XOR=3 (N=3): `In`=7'b1000111 with `CaptureEn`=1, `MisrMode`=0 → `Out`=3'b101 after one edge.
- MISR, PIN=7, XOR=3, `TAP_MASK`=0, from reset: `In`=7'b0000001 held for 3 capture cycles → `Out` sequence 001, 011, 111.
- Unload with `Sig`=3'b101, `UnloadStart` pulse:
  - Expect `ScanOut` 1,0,1 over 3 `ScanOutValid` cycles.
  - Then a single `UnloadDone` pulse.
  - Then `Out`=3'b101 and `Busy`=0.
- Simultaneous `UnloadStart` and `CaptureEn` in IDLE with `Sig`=3'b110:
  - Unload emits 0,1,1.
  - `Sig` is unchanged; the capture is dropped.
  - A `CaptureEn` during UNLOAD has no effect.
- `Reset` asserted on the 2nd UNLOAD cycle:
  - Next cycle: `Busy`=0, `ScanOutValid`=0, `Out`=0, no `UnloadDone`.
  - A new `UnloadStart` then runs normally.
- PIN=1 (N=1) and, as a separate build, PIN=8 with XOR=3:
  - PIN=8 gives a 2-bit last group; `In`=8'b11000000 → `Obs`=3'b000.
  - PIN=1 unload gives 1 valid cycle.
  - Build without `SWT_OBS_MISR_EN` and set `MisrMode`=1: captures are direct.

Source files
------------

// File: rtl/swt_obs_pkg.sv
// ---------------------------------------------------------------------------
// swt_obs_pkg
// Shared definitions for the SWT observation/MISR block:
//   - swt_obs_state_e : unload FSM states (IDLE, UNLOAD, DONE)
//   - obs_flop_num()  : ceil(pins / xor_size), the number of signature flops
// ---------------------------------------------------------------------------
package swt_obs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UNLOAD = 2'd1,
        ST_DONE   = 2'd2
    } swt_obs_state_e;

    function automatic int obs_flop_num(input int pins, input int xor_size);
        return (pins + xor_size - 1) / xor_size;
    endfunction

endpackage

// File: rtl/swt_obs_xor_compact.sv
// ---------------------------------------------------------------------------
// swt_obs_xor_compact
// Purely combinational XOR fold of the observed pins into OBS_FLOP_NUM groups.
// Group g is the parity of pins [g*S +: S]; the last group may be narrower
// when OBS_PIN_NUM is not a multiple of S (S = OBS_XOR_SIZE).
// Ports:
//   in_i  [OBS_PIN_NUM-1:0]  observed address/control pins
//   obs_o [OBS_FLOP_NUM-1:0] per-group parity
// ---------------------------------------------------------------------------
module swt_obs_xor_compact #(
    parameter int OBS_PIN_NUM  = 1,
    parameter int OBS_XOR_SIZE = 3,
    parameter int OBS_FLOP_NUM = 1
) (
    input  logic [OBS_PIN_NUM-1:0]  in_i,
    output logic [OBS_FLOP_NUM-1:0] obs_o
);

    // Each pin lands in group p / S, which naturally leaves the tail group
    // holding only the leftover pins.
    always_comb begin
        obs_o = '0;
        for (int p = 0; p < OBS_PIN_NUM; p++) begin
            obs_o[p / OBS_XOR_SIZE] = obs_o[p / OBS_XOR_SIZE] ^ in_i[p];
        end
    end

endmodule

// File: rtl/swt_obs_misr.sv
// ---------------------------------------------------------------------------
// swt_obs_misr
// Observation block for memory Scan Write-Thru address/control paths.
// Observed pins are XOR-folded into N = OBS_FLOP_NUM groups and captured into
// the signature register Sig, either directly or as a MISR. A start/done
// serial unload shifts Sig out LSB first and restores it afterwards.
//
// Build option: SWT_OBS_MISR_EN
//   defined   - MISR update with TAP_MASK feedback, selected by MisrMode
//   undefined - every capture is direct, MisrMode/TAP_MASK unused
//
// Ports:
//   Clock        memory port clock (single domain)
//   Reset        synchronous, active-high
//   In           observed pins [OBS_PIN_NUM-1:0]
//   CaptureEn    update Sig this cycle (IDLE only)
//   MisrMode     0 = direct capture, 1 = MISR accumulate
//   UnloadStart  request serial unload (sampled in IDLE only)
//   ScanOut      serial signature bit, LSB first, 0 when not valid
//   ScanOutValid ScanOut carries a signature bit this cycle
//   UnloadDone   one-cycle pulse after the last bit
//   Busy         FSM not IDLE
//   Out          registered signature Sig [OBS_FLOP_NUM-1:0]
//
// Unload handshake: UnloadStart is a request seen only while Busy is low;
// once accepted, ScanOutValid is high for exactly N cycles (bit 0 first),
// then UnloadDone is high for one cycle with Busy still high, after which
// Busy drops. Requests while Busy is high are dropped, not queued.
// ---------------------------------------------------------------------------
module swt_obs_misr
    import swt_obs_pkg::*;
#(
    parameter int OBS_PIN_NUM  = 1,
    parameter int OBS_XOR_SIZE = 3,
    parameter int OBS_FLOP_NUM = obs_flop_num(OBS_PIN_NUM, OBS_XOR_SIZE),
    parameter logic [OBS_FLOP_NUM-1:0] TAP_MASK = '0
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic [OBS_PIN_NUM-1:0]  In,
    input  logic                    CaptureEn,
    input  logic                    MisrMode,
    input  logic                    UnloadStart,
    output logic                    ScanOut,
    output logic                    ScanOutValid,
    output logic                    UnloadDone,
    output logic                    Busy,
    output logic [OBS_FLOP_NUM-1:0] Out
);

    localparam int N     = OBS_FLOP_NUM;
    localparam int CNT_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(N - 1);

    swt_obs_state_e   state_q, state_d;
    logic [N-1:0]     sig_q, sig_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     obs;
    logic [N-1:0]     sig_rot;
    logic [N-1:0]     sig_cap;

    swt_obs_xor_compact #(
        .OBS_PIN_NUM  (OBS_PIN_NUM),
        .OBS_XOR_SIZE (OBS_XOR_SIZE),
        .OBS_FLOP_NUM (N)
    ) u_xor (
        .in_i  (In),
        .obs_o (obs)
    );

    // Rotate right by one: Sig[0] wraps to Sig[N-1]. After N rotations the
    // register is back to its pre-unload value.
    always_comb begin
        sig_rot = sig_q;
        for (int k = 0; k < N; k++) begin
            sig_rot[k] = sig_q[(k + 1) % N];
        end
    end

`ifdef SWT_OBS_MISR_EN
    logic [N-1:0] sig_misr;

    // Shift toward the MSB with Sig[N-1] fed back into bit 0 and into every
    // bit whose tap is set. For N = 1 this reduces to Sig[0] ^ Obs[0].
    always_comb begin
        sig_misr    = '0;
        sig_misr[0] = sig_q[N-1] ^ obs[0];
        for (int k = 1; k < N; k++) begin
            sig_misr[k] = sig_q[k-1] ^ obs[k] ^ (TAP_MASK[k] & sig_q[N-1]);
        end
    end

    assign sig_cap = MisrMode ? sig_misr : obs;
`else
    logic unused_misr;
    assign unused_misr = ^{MisrMode, TAP_MASK};
    assign sig_cap     = obs;
`endif

    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                // An unload request wins over a capture in the same cycle.
                if (UnloadStart) begin
                    state_d = ST_UNLOAD;
                    cnt_d   = CNT_LOAD;
                end else if (CaptureEn) begin
                    sig_d = sig_cap;
                end
            end
            ST_UNLOAD: begin
                sig_d = sig_rot;
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            sig_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ScanOutValid = (state_q == ST_UNLOAD);
    assign ScanOut      = ScanOutValid & sig_q[0];
    assign UnloadDone   = (state_q == ST_DONE);
    assign Busy         = (state_q != ST_IDLE);
    assign Out          = sig_q;

endmodule

// File: tb/tb_swt_obs_misr.sv
// ---------------------------------------------------------------------------
// tb_swt_obs_misr
// Bench for swt_obs_misr with three instances:
//   d7 : PIN=7, XOR=3 (N=3), TAP_MASK=000
//   d8 : PIN=8, XOR=3 (N=3, 2-bit last group), TAP_MASK=110
//   d1 : PIN=1 (N=1)
// Honours SWT_OBS_MISR_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_swt_obs_misr;

`ifdef SWT_OBS_MISR_EN
    localparam bit MISR_EN = 1'b1;
`else
    localparam bit MISR_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // index 0 = d7, index 1 = d8
    logic [7:0] r_in    [2];
    logic       r_cap   [2];
    logic       r_mode  [2];
    logic       r_start [2];
    logic [2:0] o_out   [2];
    logic       o_scan  [2];
    logic       o_valid [2];
    logic       o_done  [2];
    logic       o_busy  [2];

    logic in1, cap1, mode1, start1;
    logic out1, scan1, valid1, done1, busy1;

    swt_obs_misr #(.OBS_PIN_NUM(7), .OBS_XOR_SIZE(3), .TAP_MASK(3'b000)) d7 (
        .Clock(clk), .Reset(rst), .In(r_in[0][6:0]), .CaptureEn(r_cap[0]),
        .MisrMode(r_mode[0]), .UnloadStart(r_start[0]), .ScanOut(o_scan[0]),
        .ScanOutValid(o_valid[0]), .UnloadDone(o_done[0]), .Busy(o_busy[0]),
        .Out(o_out[0])
    );

    swt_obs_misr #(.OBS_PIN_NUM(8), .OBS_XOR_SIZE(3), .TAP_MASK(3'b110)) d8 (
        .Clock(clk), .Reset(rst), .In(r_in[1]), .CaptureEn(r_cap[1]),
        .MisrMode(r_mode[1]), .UnloadStart(r_start[1]), .ScanOut(o_scan[1]),
        .ScanOutValid(o_valid[1]), .UnloadDone(o_done[1]), .Busy(o_busy[1]),
        .Out(o_out[1])
    );

    swt_obs_misr #(.OBS_PIN_NUM(1), .OBS_XOR_SIZE(3)) d1 (
        .Clock(clk), .Reset(rst), .In(in1), .CaptureEn(cap1),
        .MisrMode(mode1), .UnloadStart(start1), .ScanOut(scan1),
        .ScanOutValid(valid1), .UnloadDone(done1), .Busy(busy1),
        .Out(out1)
    );

    // ---------------- scoreboard ----------------
    int n_cmp;
    int n_err;
    logic exp_q0[$];
    logic exp_q1[$];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    // Group g parity of the pins that actually exist on this instance.
    function automatic logic [2:0] ref_fold(input logic [7:0] v, input int pins);
        logic [2:0] r;
        int mask;
        mask = (1 << pins) - 1;
        for (int g = 0; g < 3; g++) begin
            r[g] = (($countones(int'(v) & mask & (7 << (3 * g))) % 2) != 0);
        end
        return r;
    endfunction

    // Signature as a Galois LFSR step: shift up, inject Obs, and fold the
    // outgoing MSB back into bit 0 plus the tapped bits.
    function automatic logic [2:0] ref_misr(input logic [2:0] s, input logic [2:0] ob,
                                            input logic [2:0] tap);
        logic [2:0] n;
        n = {s[1:0], 1'b0} ^ ob;
        if (s[2]) n = n ^ (tap | 3'b001);
        return n;
    endfunction

    function automatic logic [2:0] rotr(input logic [2:0] v, input int p);
        logic [5:0] w;
        w = {v, v};
        return w[p +: 3];
    endfunction

    logic [2:0] m_sig   [2];
    int         m_phase [2];   // -1 idle, 0..2 bit being shifted, 3 done

    task automatic model_step(input int d);
        int         pins;
        logic [2:0] tap;
        pins = (d == 0) ? 7 : 8;
        tap  = (d == 0) ? 3'b000 : 3'b110;
        if (m_phase[d] == -1) begin
            if (r_start[d]) begin
                m_phase[d] = 0;
                for (int b = 0; b < 3; b++) begin
                    if (d == 0) exp_q0.push_back(m_sig[d][b]);
                    else        exp_q1.push_back(m_sig[d][b]);
                end
            end else if (r_cap[d]) begin
                if (MISR_EN && r_mode[d])
                    m_sig[d] = ref_misr(m_sig[d], ref_fold(r_in[d], pins), tap);
                else
                    m_sig[d] = ref_fold(r_in[d], pins);
            end
        end else if (m_phase[d] < 3) begin
            m_phase[d] = m_phase[d] + 1;
        end else begin
            m_phase[d] = -1;
        end
    endtask

    task automatic model_check(input int d);
        logic       ev;
        logic       eb;
        logic [2:0] eo;
        ev = (m_phase[d] >= 0) && (m_phase[d] <= 2);
        eo = ev ? rotr(m_sig[d], m_phase[d]) : m_sig[d];
        chk($sformatf("rnd%0d_out", d), o_out[d], eo);
        chk($sformatf("rnd%0d_valid", d), o_valid[d], ev);
        chk($sformatf("rnd%0d_done", d), o_done[d], m_phase[d] == 3);
        chk($sformatf("rnd%0d_busy", d), o_busy[d], m_phase[d] != -1);
        if (ev) begin
            if (((d == 0) ? exp_q0.size() : exp_q1.size()) == 0) begin
                chk($sformatf("rnd%0d_q_empty", d), 8'd1, 8'd0);
            end else begin
                eb = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                chk($sformatf("rnd%0d_scan", d), o_scan[d], eb);
            end
        end else begin
            chk($sformatf("rnd%0d_scan_idle", d), o_scan[d], 1'b0);
        end
    endtask

    // ---------------- directed helpers ----------------
    // Pulses UnloadStart on d7 and checks the full unload of signature s.
    // CaptureEn is left as the caller set it; In is changed during the
    // unload so that any leaked capture would alter Sig.
    task automatic unload7(input logic [2:0] s, input string nm);
        r_start[0] = 1'b1;
        tick();
        r_start[0] = 1'b0;
        r_in[0]    = 8'h07;
        for (int i = 0; i < 3; i++) begin
            chk({nm, "_valid"}, o_valid[0], 1'b1);
            chk({nm, "_scan"},  o_scan[0],  s[i]);
            chk({nm, "_busy"},  o_busy[0],  1'b1);
            chk({nm, "_done0"}, o_done[0],  1'b0);
            tick();
        end
        chk({nm, "_done"},       o_done[0],  1'b1);
        chk({nm, "_done_busy"},  o_busy[0],  1'b1);
        chk({nm, "_done_valid"}, o_valid[0], 1'b0);
        chk({nm, "_done_scan"},  o_scan[0],  1'b0);
        tick();
        chk({nm, "_idle_busy"}, o_busy[0], 1'b0);
        chk({nm, "_idle_done"}, o_done[0], 1'b0);
        chk({nm, "_sig_kept"},  o_out[0],  s);
        r_cap[0] = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0] in7;
        logic [7:0] in8;
        logic       cap;
        logic [2:0] exp7;
        logic [2:0] exp8;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [2:0] misr_exp[3];

        n_cmp = 0;
        n_err = 0;

        vecs[0] = '{8'b01000111, 8'b11000000, 1'b1, 3'b101, 3'b000};
        vecs[1] = '{8'b00000000, 8'b10000000, 1'b0, 3'b101, 3'b000};
        vecs[2] = '{8'b00101100, 8'b01001001, 1'b1, 3'b001, 3'b111};
        vecs[3] = '{8'b01111111, 8'b00000110, 1'b1, 3'b111, 3'b000};
        vecs[4] = '{8'b00011000, 8'b10000000, 1'b1, 3'b000, 3'b100};
        vecs[5] = '{8'b00010010, 8'b00100011, 1'b1, 3'b011, 3'b010};
        vecs[6] = '{8'b01111111, 8'b11111111, 1'b0, 3'b011, 3'b010};

        for (int d = 0; d < 2; d++) begin
            r_in[d] = '0; r_cap[d] = 1'b0; r_mode[d] = 1'b0; r_start[d] = 1'b0;
        end
        in1 = 1'b0; cap1 = 1'b0; mode1 = 1'b0; start1 = 1'b0;

        // ---- reset ----
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_out7",   o_out[0],   3'b000);
        chk("rst_valid7", o_valid[0], 1'b0);
        chk("rst_scan7",  o_scan[0],  1'b0);
        chk("rst_done7",  o_done[0],  1'b0);
        chk("rst_busy7",  o_busy[0],  1'b0);
        chk("rst_out1",   out1,       1'b0);
        chk("rst_busy1",  busy1,      1'b0);

        // ---- direct capture table (d7 and d8) ----
        for (int v = 0; v < 7; v++) begin
            r_in[0] = vecs[v].in7;  r_cap[0] = vecs[v].cap;
            r_in[1] = vecs[v].in8;  r_cap[1] = vecs[v].cap;
            tick();
            chk($sformatf("vec%0d_out7", v), o_out[0], vecs[v].exp7);
            chk($sformatf("vec%0d_out8", v), o_out[1], vecs[v].exp8);
            chk($sformatf("vec%0d_busy7", v), o_busy[0], 1'b0);
        end
        r_cap[0] = 1'b0; r_cap[1] = 1'b0;

        // ---- MISR accumulate from zero (direct when MISR is not built) ----
        r_in[0] = 8'h00; r_cap[0] = 1'b1;
        tick();
        chk("misr_clear", o_out[0], 3'b000);
        misr_exp[0] = MISR_EN ? 3'b001 : 3'b001;
        misr_exp[1] = MISR_EN ? 3'b011 : 3'b001;
        misr_exp[2] = MISR_EN ? 3'b111 : 3'b001;
        r_in[0] = 8'b0000001; r_mode[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("misr_step%0d", i), o_out[0], misr_exp[i]);
        end
        r_cap[0] = 1'b0; r_mode[0] = 1'b0;

        // ---- plain unload of 101 ----
        r_in[0] = 8'b01000111; r_cap[0] = 1'b1;
        tick();
        r_cap[0] = 1'b0;
        chk("load101", o_out[0], 3'b101);
        unload7(3'b101, "unl101");

        // ---- unload and capture together: capture dropped ----
        r_in[0] = 8'b01001000; r_cap[0] = 1'b1;
        tick();
        chk("load110", o_out[0], 3'b110);
        r_in[0] = 8'b01000111;   // would capture 101 if not dropped
        r_cap[0] = 1'b1;         // stays high through the unload
        unload7(3'b110, "unl110");

        // ---- UnloadStart while busy is ignored ----
        r_start[0] = 1'b1;
        tick();
        chk("busy_start_v", o_valid[0], 1'b1);
        tick();
        tick();
        tick();
        chk("busy_start_done", o_done[0], 1'b1);
        r_start[0] = 1'b0;
        tick();
        chk("busy_start_idle", o_busy[0], 1'b0);

        // ---- reset on the 2nd UNLOAD cycle ----
        r_in[0] = 8'b01000111; r_cap[0] = 1'b1;
        tick();
        r_cap[0] = 1'b0;
        r_start[0] = 1'b1;
        tick();
        r_start[0] = 1'b0;
        chk("rmid_c1_scan", o_scan[0], 1'b1);
        tick();
        chk("rmid_c2_valid", o_valid[0], 1'b1);
        chk("rmid_c2_scan",  o_scan[0],  1'b0);
        rst = 1'b1;
        tick();
        chk("rmid_busy",  o_busy[0],  1'b0);
        chk("rmid_valid", o_valid[0], 1'b0);
        chk("rmid_out",   o_out[0],   3'b000);
        chk("rmid_done",  o_done[0],  1'b0);
        chk("rmid_scan",  o_scan[0],  1'b0);
        rst = 1'b0;
        tick();
        chk("rmid_nodone", o_done[0], 1'b0);
        r_in[0] = 8'b00010010; r_cap[0] = 1'b1;
        tick();
        r_cap[0] = 1'b0;
        chk("rmid_load011", o_out[0], 3'b011);
        unload7(3'b011, "rerun");

        // ---- single-flop instance ----
        in1 = 1'b1; cap1 = 1'b1;
        tick();
        cap1 = 1'b0;
        chk("n1_cap", out1, 1'b1);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("n1_valid", valid1, 1'b1);
        chk("n1_scan",  scan1,  1'b1);
        chk("n1_busy",  busy1,  1'b1);
        tick();
        chk("n1_valid_end", valid1, 1'b0);
        chk("n1_done",      done1,  1'b1);
        tick();
        chk("n1_idle", busy1, 1'b0);
        chk("n1_kept", out1,  1'b1);
        mode1 = 1'b1; cap1 = 1'b1; in1 = 1'b1;
        tick();
        cap1 = 1'b0; mode1 = 1'b0;
        chk("n1_mode1", out1, MISR_EN ? 1'b0 : 1'b1);

        // ---- randomized run against the reference model ----
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            r_cap[d] = 1'b0; r_start[d] = 1'b0; r_mode[d] = 1'b0;
            m_sig[d] = 3'b000; m_phase[d] = -1;
        end
        exp_q0.delete();
        exp_q1.delete();
        tick();
        tick();
        rst = 1'b0;
        for (int it = 0; it < 400; it++) begin
            for (int d = 0; d < 2; d++) begin
                r_in[d]    = 8'($urandom_range(0, 255));
                r_cap[d]   = 1'($urandom_range(0, 1));
                r_mode[d]  = 1'($urandom_range(0, 1));
                r_start[d] = ($urandom_range(0, 5) == 0);
                model_step(d);
            end
            tick();
            for (int d = 0; d < 2; d++) model_check(d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench did not complete");
    end

endmodule
